decodifica_jogada: RTL and testbench

DECODIFICA_JOGADA -- requirements
Module: decodifica_jogada

---
 rtl/jogada_pkg.sv | 27 ++
 rtl/decodifica_jogada_paridade_par.sv | 11 +
 rtl/decodifica_jogada.sv | 156 +++++++++++++++
 tb/tb_decodifica_jogada.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogada_pkg.sv
// Shared definitions for the move decoder and the future move encoder/transmitter.
package jogada_pkg;

  // Width of a plain or encoded move.
  localparam int unsigned LARG_JOGADA = 3;

  // Serial frame length: start, three encoded bits, parity, stop.
  localparam int unsigned TAM_QUADRO = 6;

  // Encoding key: encoded = plain XOR CHAVE.
  localparam logic [LARG_JOGADA-1:0] CHAVE = 3'b101;

  // Receiver states.
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  // Even-parity bit over one move: 1 when the move has an odd number of ones.
  function automatic logic paridade3(input logic [LARG_JOGADA-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/decodifica_jogada_paridade_par.sv
// Combinational 3-bit even-parity generator, shared by receiver and transmitter.
module paridade_par
  import jogada_pkg::*;
(
  input  logic [LARG_JOGADA-1:0] i_dados,
  output logic                   o_paridade
);

  assign o_paridade = paridade3(i_dados);

endmodule

// File: rtl/decodifica_jogada.sv
// Serial move receiver: deframes start/3 data/parity/stop, checks parity and
// stop bit, decodes the move with CHAVE and presents it with a valid/ack handshake.
module decodifica_jogada #(
  parameter int unsigned                           DIV   = 4,
  parameter logic [jogada_pkg::LARG_JOGADA-1:0]    CHAVE = jogada_pkg::CHAVE
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     rx,
  input  logic                                     ack,
  output logic [jogada_pkg::LARG_JOGADA-1:0]       Jogada,
  output logic                                     valid,
  output logic                                     erro_paridade,
  output logic                                     sobrescrita,
  output logic                                     ocupado
);
  import jogada_pkg::*;

  // Mid-bit sample point and last cycle of a bit period.
  localparam logic [3:0] MEIO       = 4'(DIV / 2);
  localparam logic [3:0] FIM        = 4'(DIV - 1);
  localparam logic [1:0] ULTIMO_BIT = 2'(LARG_JOGADA - 1);

  estado_t                r_estado;
  estado_t                w_prox_estado;
  logic [3:0]             r_cont;
  logic [1:0]             r_nbit;
  logic [LARG_JOGADA-1:0] r_dados;
  logic                   r_par;
  logic [LARG_JOGADA-1:0] r_jogada;
  logic                   r_valid;
  logic                   r_erro;
  logic                   r_sobre;
  logic                   r_ocupado;

  logic                   w_par_calc;
  logic                   w_amostra;
  logic                   w_fim_bit;
  logic                   w_completa;
  logic                   w_quadro_ok;
  logic                   w_aceite;

  paridade_par u_paridade (
    .i_dados    (r_dados),
    .o_paridade (w_par_calc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next-state logic: start detection, glitch rejection and bit sequencing.
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (!rx) w_prox_estado = INICIO;
        else     w_prox_estado = OCIOSO;
      end
      INICIO: begin
        if (w_amostra && rx) w_prox_estado = OCIOSO;
        else if (w_fim_bit)  w_prox_estado = DADOS;
        else                 w_prox_estado = INICIO;
      end
      DADOS: begin
        if (w_fim_bit && (r_nbit == ULTIMO_BIT)) w_prox_estado = PARIDADE;
        else                                     w_prox_estado = DADOS;
      end
      PARIDADE: begin
        if (w_fim_bit) w_prox_estado = PARADA;
        else           w_prox_estado = PARIDADE;
      end
      PARADA: begin
        if (w_amostra) w_prox_estado = OCIOSO;
        else           w_prox_estado = PARADA;
      end
      default: w_prox_estado = OCIOSO;
    endcase
  end

  // Decode of sample points, frame completion, frame check and handshake.
  always_comb begin
    w_amostra   = (r_cont == MEIO);
    w_fim_bit   = (r_cont == FIM);
    w_completa  = 1'b0;
    w_quadro_ok = 1'b0;
    w_aceite    = r_valid && ack;
    if (r_estado == PARADA) begin
      w_completa  = w_amostra;
      w_quadro_ok = (w_par_calc == r_par) && rx;
    end else begin
      w_completa  = 1'b0;
      w_quadro_ok = 1'b0;
    end
  end

  // Cycle/bit counters and capture of data and parity bits at mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont  <= 4'd0;
      r_nbit  <= 2'd0;
      r_dados <= 3'b000;
      r_par   <= 1'b0;
    end else if (r_estado == OCIOSO) begin
      r_cont <= 4'd0;
      r_nbit <= 2'd0;
    end else begin
      if (w_fim_bit) begin
        r_cont <= 4'd0;
        if (r_estado == DADOS) r_nbit <= r_nbit + 2'd1;
      end else begin
        r_cont <= r_cont + 4'd1;
      end
      if (w_amostra && (r_estado == DADOS))    r_dados <= {rx, r_dados[LARG_JOGADA-1:1]};
      if (w_amostra && (r_estado == PARIDADE)) r_par   <= rx;
    end
  end

  // Output registers: move delivery, error and overrun flags, busy indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jogada  <= 3'b000;
      r_valid   <= 1'b0;
      r_erro    <= 1'b0;
      r_sobre   <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_ocupado <= (w_prox_estado != OCIOSO);
      if (w_completa && w_quadro_ok) begin
        r_jogada <= r_dados ^ CHAVE;
        r_valid  <= 1'b1;
        r_erro   <= 1'b0;
        if (r_valid && !ack) r_sobre <= 1'b1;
        else if (w_aceite)   r_sobre <= 1'b0;
      end else begin
        if (w_completa) r_erro <= 1'b1;
        if (w_aceite) begin
          r_valid <= 1'b0;
          r_sobre <= 1'b0;
        end
      end
    end
  end

  assign Jogada        = r_jogada;
  assign valid         = r_valid;
  assign erro_paridade = r_erro;
  assign sobrescrita   = r_sobre;
  assign ocupado       = r_ocupado;

endmodule

// File: tb/tb_decodifica_jogada.sv
// Directed bench for decodifica_jogada with a time-based reference model.
module tb_decodifica_jogada;
  import jogada_pkg::*;

  localparam int         DIV = 4;
  localparam logic [2:0] K   = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ack;
  logic [2:0] Jogada;
  logic       valid;
  logic       erro_paridade;
  logic       sobrescrita;
  logic       ocupado;

  decodifica_jogada #(.DIV(DIV), .CHAVE(K)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .ack           (ack),
    .Jogada        (Jogada),
    .valid         (valid),
    .erro_paridade (erro_paridade),
    .sobrescrita   (sobrescrita),
    .ocupado       (ocupado)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_ok    = 0;
  int ciclo   = 0;
  bit compara = 1'b0;
  int t_sub   = -1;
  logic valid_ant = 1'b0;

  // Edge counter: value seen at a negedge = rising edges so far.
  always @(posedge clk) ciclo <= ciclo + 1;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_total++;
    if (atual === esperado) n_ok++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nome, atual, esperado, ciclo);
  endtask

  // Reference model: samples rx at absolute times measured from the start edge.
  typedef struct {
    bit         ocup;
    int         t0;
    logic [2:0] e;
    logic       p;
    logic [2:0] jog;
    logic       val;
    logic       erro;
    logic       sob;
  } modelo_t;

  modelo_t m;

  function automatic modelo_t passo(input modelo_t s, input logic r, input logic a, input int n);
    modelo_t x;
    bit      fim;
    bit      bom;
    bit      consumido;
    int      desl;
    int      k;
    x = s;
    fim = 1'b0;
    bom = 1'b0;
    if (!x.ocup) begin
      if (r == 1'b0) begin
        x.ocup = 1'b1;
        x.t0   = n;
      end
    end else begin
      desl = n - x.t0 - 1 - DIV / 2;
      if (desl >= 0 && (desl % DIV) == 0) begin
        k = desl / DIV;
        if (k == 0) begin
          if (r) x.ocup = 1'b0;
        end else if (k <= 3) begin
          x.e[k-1] = r;
        end else if (k == 4) begin
          x.p = r;
        end else begin
          fim    = 1'b1;
          bom    = ((x.e[0] + x.e[1] + x.e[2] + x.p) % 2 == 0) && (r == 1'b1);
          x.ocup = 1'b0;
        end
      end
    end
    consumido = s.val && a;
    if (fim && bom) begin
      x.sob  = (s.val && !a) ? 1'b1 : (consumido ? 1'b0 : s.sob);
      x.jog  = x.e ^ K;
      x.val  = 1'b1;
      x.erro = 1'b0;
    end else begin
      if (fim) x.erro = 1'b1;
      if (consumido) begin
        x.val = 1'b0;
        x.sob = 1'b0;
      end
    end
    return x;
  endfunction

  function automatic modelo_t modelo_reset();
    modelo_t x;
    x.ocup = 1'b0; x.t0 = 0; x.e = 3'b000; x.p = 1'b0;
    x.jog = 3'b000; x.val = 1'b0; x.erro = 1'b0; x.sob = 1'b0;
    return x;
  endfunction

  // Model update on every rising edge, cleared asynchronously by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= modelo_reset();
    else        m <= passo(m, rx, ack, ciclo);
  end

  // Per-cycle comparison of all outputs against the model, plus valid-rise timestamp.
  always begin
    @(posedge clk);
    #2;
    if (compara) begin
      check("jogada",  {29'd0, Jogada},        {29'd0, m.jog});
      check("valid",   {31'd0, valid},         {31'd0, m.val});
      check("erro",    {31'd0, erro_paridade}, {31'd0, m.erro});
      check("sobre",   {31'd0, sobrescrita},   {31'd0, m.sob});
      check("ocupado", {31'd0, ocupado},       {31'd0, m.ocup});
    end
    if (valid && !valid_ant) t_sub = ciclo - 1;
    valid_ant = valid;
  end

  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame from a negedge; optional ack pulse exactly on the stop-sample edge.
  task automatic envia(input logic [2:0] e, input logic p, input logic stop,
                       input bit ack_fim, output int t_ini);
    logic [TAM_QUADRO-1:0] q;
    q = {stop, p, e[2], e[1], e[0], 1'b0};
    t_ini = ciclo;
    for (int i = 0; i < TAM_QUADRO; i++) begin
      rx = q[i];
      if (i == TAM_QUADRO - 1 && ack_fim) begin
        espera(DIV - 1);
        ack = 1'b1;
        espera(1);
        ack = 1'b0;
      end else begin
        espera(DIV);
      end
    end
    rx = 1'b1;
  endtask

  task automatic pulso_ack();
    ack = 1'b1;
    espera(1);
    ack = 1'b0;
  endtask

  int t0;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;
    espera(3);
    check("rst_jogada",  {29'd0, Jogada},        32'd0);
    check("rst_valid",   {31'd0, valid},         32'd0);
    check("rst_erro",    {31'd0, erro_paridade}, 32'd0);
    check("rst_sobre",   {31'd0, sobrescrita},   32'd0);
    check("rst_ocupado", {31'd0, ocupado},       32'd0);
    compara = 1'b1;
    rst_n = 1'b1;
    espera(50);
    check("idle_valid",   {31'd0, valid},   32'd0);
    check("idle_ocupado", {31'd0, ocupado}, 32'd0);
    check("idle_jogada",  {29'd0, Jogada},  32'd0);

    // Good frame, encoded 101 -> plain 000; latency and handshake.
    envia(3'b101, 1'b0, 1'b1, 1'b0, t0);
    check("latencia",   t_sub - t0,          32'd23);
    check("f1_jogada",  {29'd0, Jogada},     32'd0);
    check("f1_valid",   {31'd0, valid},      32'd1);
    pulso_ack();
    check("f1_ack_valid", {31'd0, valid},    32'd0);
    espera(2);
    pulso_ack();
    espera(2);
    check("ack_ocioso", {31'd0, valid},      32'd0);

    // Parity error, then a good frame clears the error.
    envia(3'b011, 1'b1, 1'b1, 1'b0, t0);
    check("f2_erro",  {31'd0, erro_paridade}, 32'd1);
    check("f2_valid", {31'd0, valid},         32'd0);
    espera(3);
    envia(3'b110, 1'b0, 1'b1, 1'b0, t0);
    check("f3_jogada", {29'd0, Jogada},        32'd3);
    check("f3_erro",   {31'd0, erro_paridade}, 32'd0);
    pulso_ack();

    // Overrun: two frames without ack.
    espera(3);
    envia(3'b001, 1'b1, 1'b1, 1'b0, t0);
    espera(3);
    envia(3'b010, 1'b1, 1'b1, 1'b0, t0);
    check("ov_jogada", {29'd0, Jogada},      32'd7);
    check("ov_valid",  {31'd0, valid},       32'd1);
    check("ov_sobre",  {31'd0, sobrescrita}, 32'd1);
    pulso_ack();
    check("ov_ack_sobre", {31'd0, sobrescrita}, 32'd0);
    check("ov_ack_valid", {31'd0, valid},       32'd0);

    // Bad stop bit with correct parity.
    espera(3);
    envia(3'b100, 1'b1, 1'b0, 1'b0, t0);
    check("stop_erro",   {31'd0, erro_paridade}, 32'd1);
    check("stop_jogada", {29'd0, Jogada},        32'd7);

    // One-cycle low glitch while idle.
    espera(4);
    rx = 1'b0;
    espera(1);
    rx = 1'b1;
    espera(10);
    check("gl_ocupado", {31'd0, ocupado},       32'd0);
    check("gl_erro",    {31'd0, erro_paridade}, 32'd1);
    check("gl_valid",   {31'd0, valid},         32'd0);
    check("gl_jogada",  {29'd0, Jogada},        32'd7);

    // Good frame left pending, then a new one completing together with ack.
    envia(3'b000, 1'b0, 1'b1, 1'b0, t0);
    check("f6_jogada", {29'd0, Jogada}, 32'd5);
    espera(3);
    envia(3'b111, 1'b1, 1'b1, 1'b1, t0);
    check("sim_jogada", {29'd0, Jogada},      32'd2);
    check("sim_valid",  {31'd0, valid},       32'd1);
    check("sim_sobre",  {31'd0, sobrescrita}, 32'd0);

    // Reset pulse in the middle of the data bits.
    espera(3);
    rx = 1'b0;
    espera(DIV);
    rx = 1'b1;
    espera(2);
    check("pre_rst_ocupado", {31'd0, ocupado}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",   {31'd0, valid},         32'd0);
    check("arst_jogada",  {29'd0, Jogada},        32'd0);
    check("arst_ocupado", {31'd0, ocupado},       32'd0);
    check("arst_erro",    {31'd0, erro_paridade}, 32'd0);
    espera(2);
    rst_n = 1'b1;
    espera(12);
    check("pos_rst_ocupado", {31'd0, ocupado}, 32'd0);
    envia(3'b100, 1'b1, 1'b1, 1'b0, t0);
    check("f8_jogada", {29'd0, Jogada}, 32'd1);
    check("f8_valid",  {31'd0, valid},  32'd1);
    pulso_ack();
    espera(5);

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
